kbd_scancode_ctrl: RTL and testbench

- Sits directly after the PS/2 bit receiver. Takes its validated byte stream (byte plus one-cycle new-byte strobe) and assembles multi-byte set-2 scan-code sequences into single key events.
- Handles the E0 (extended), F0 (break) and E1 (pause) prefixes and filters protocol bytes.
- Tracks modifier state and buffers events in a small FIFO with a valid/ready handshake toward game logic.

---
 rtl/kbd_scancode_ctrl_pkg.sv | 51 +++++
 rtl/kbd_scancode_ctrl_if.sv | 25 ++
 rtl/kbd_scancode_ctrl_evt_fifo.sv | 67 ++++++
 rtl/kbd_scancode_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_kbd_scancode_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/kbd_scancode_ctrl_pkg.sv
// Shared types and constants for the PS/2 set-2 scan-code assembler.
// Holds the decoder state encoding, the queued event format and the protocol byte values.
package kbd_pkg;

    typedef enum logic [2:0] {
        IDLE_ST,
        GOT_E0_ST,
        GOT_F0_ST,
        GOT_E0F0_ST,
        PAUSE_SKIP_ST
    } kbd_state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } kbd_event_t;

    localparam logic [7:0] BYTE_E0       = 8'hE0;
    localparam logic [7:0] BYTE_F0       = 8'hF0;
    localparam logic [7:0] BYTE_E1       = 8'hE1;

    localparam logic [7:0] BYTE_BAT_OK   = 8'hAA;
    localparam logic [7:0] BYTE_ACK      = 8'hFA;
    localparam logic [7:0] BYTE_RESEND   = 8'hFE;
    localparam logic [7:0] BYTE_ECHO     = 8'hEE;
    localparam logic [7:0] BYTE_ERR_00   = 8'h00;
    localparam logic [7:0] BYTE_ERR_FF   = 8'hFF;

    localparam logic [7:0] CODE_LSHIFT   = 8'h12;
    localparam logic [7:0] CODE_RSHIFT   = 8'h59;
    localparam logic [7:0] CODE_CTRL     = 8'h14;
    localparam logic [7:0] CODE_ALT      = 8'h11;

    localparam int PAUSE_TAIL_LEN = 7;

    // Keyboard housekeeping bytes that never describe a key.
    function automatic logic is_ignored(input logic [7:0] b);
        return (b == BYTE_BAT_OK) || (b == BYTE_ACK) || (b == BYTE_RESEND) ||
               (b == BYTE_ECHO)   || (b == BYTE_ERR_00) || (b == BYTE_ERR_FF);
    endfunction

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == BYTE_E0) || (b == BYTE_F0) || (b == BYTE_E1);
    endfunction

    function automatic logic is_shift(input logic [7:0] b);
        return (b == CODE_LSHIFT) || (b == CODE_RSHIFT);
    endfunction

endpackage

// File: rtl/kbd_scancode_ctrl_if.sv
// Key-event handshake between the scan-code assembler and the game logic.
// The master presents the FIFO head; the slave accepts it with ev_ready.
interface kbd_scancode_ctrl_if;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_brk;

    modport master (
        output ev_valid,
        output ev_code,
        output ev_ext,
        output ev_brk,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_code,
        input  ev_ext,
        input  ev_brk,
        output ev_ready
    );
endinterface

// File: rtl/kbd_scancode_ctrl_evt_fifo.sv
// Synchronous FIFO of key events with a combinational head.
// A push into a full FIFO succeeds only when a pop frees a slot in the same cycle.
module kbd_evt_fifo
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_push,
    input  kbd_event_t                    i_data,
    input  logic                          i_pop,
    output kbd_event_t                    o_head,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_drop
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    kbd_event_t      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            w_do_push;
    logic            w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_drop    = i_push & o_full & ~w_do_pop;
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // NOTE: storage has no reset; occupancy and pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/kbd_scancode_ctrl.sv
// Assembles PS/2 set-2 byte sequences (E0/F0/E1 prefixes) into single key events,
// tracks modifier keys and queues events toward the game logic.
module kbd_scancode_ctrl
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    byte_in,
    input  logic                          byte_new,
    kbd_scancode_ctrl_if.master           ev_if,
    output logic [$clog2(FIFO_DEPTH):0]   ev_count,
    output logic                          mod_shift,
    output logic                          mod_ctrl,
    output logic                          mod_alt,
    output logic                          err,
    output logic                          ovf
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    kbd_state_t      r_state;
    kbd_state_t      w_state_nxt;
    kbd_state_t      w_idle_state;
    logic            w_idle_emit;

    logic [2:0]      r_skip_cnt;
    logic [TO_W-1:0] r_to_cnt;
    logic            w_tail_done;
    logic            w_timeout;

    logic            w_emit;
    kbd_event_t      w_evt;
    logic            w_err;

    kbd_event_t      w_head;
    logic            w_full;
    logic            w_empty;
    logic            w_drop;
    logic            w_pop;

    logic            r_shift;
    logic            r_ctrl;
    logic            r_alt;
    logic            r_err;
    logic            r_ovf;

    assign w_tail_done = (r_skip_cnt == 3'(PAUSE_TAIL_LEN - 1));
    assign w_timeout   = (r_state != IDLE_ST) && !byte_new &&
                         (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // How a byte is handled from IDLE; prefix errors in other states reuse this.
    // NOTE: every always_comb assigns its outputs a default first so no latch is inferred.
    always_comb begin
        w_idle_state = IDLE_ST;
        w_idle_emit  = 1'b1;
        case (byte_in)
            BYTE_E0: begin w_idle_state = GOT_E0_ST;     w_idle_emit = 1'b0; end
            BYTE_F0: begin w_idle_state = GOT_F0_ST;     w_idle_emit = 1'b0; end
            BYTE_E1: begin w_idle_state = PAUSE_SKIP_ST; w_idle_emit = 1'b0; end
            default: w_idle_emit = !is_ignored(byte_in);
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE_ST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (byte_new) begin
            case (r_state)
                IDLE_ST: w_state_nxt = w_idle_state;
                GOT_E0_ST: begin
                    if (byte_in == BYTE_F0)      w_state_nxt = GOT_E0F0_ST;
                    else if (byte_in == BYTE_E0) w_state_nxt = GOT_E0_ST;
                    else if (byte_in == BYTE_E1) w_state_nxt = w_idle_state;
                    else if (is_ignored(byte_in)) w_state_nxt = GOT_E0_ST;
                    else                         w_state_nxt = IDLE_ST;
                end
                GOT_F0_ST, GOT_E0F0_ST: begin
                    w_state_nxt = is_prefix(byte_in) ? w_idle_state : IDLE_ST;
                end
                PAUSE_SKIP_ST: begin
                    if (w_tail_done) w_state_nxt = IDLE_ST;
                end
                default: w_state_nxt = IDLE_ST;
            endcase
        end else if (w_timeout) begin
            w_state_nxt = IDLE_ST;
        end
    end

    always_comb begin
        w_emit = 1'b0;
        w_err  = 1'b0;
        w_evt  = '{ext: 1'b0, brk: 1'b0, code: byte_in};
        if (byte_new) begin
            case (r_state)
                IDLE_ST: w_emit = w_idle_emit;
                GOT_E0_ST: begin
                    if (byte_in == BYTE_E1) begin
                        w_err = 1'b1;
                    end else if (!is_prefix(byte_in) && !is_shift(byte_in) &&
                                 !is_ignored(byte_in)) begin
                        w_emit    = 1'b1;
                        w_evt.ext = 1'b1;
                    end
                end
                GOT_F0_ST: begin
                    if (is_prefix(byte_in)) begin
                        w_err = 1'b1;
                    end else begin
                        w_emit    = 1'b1;
                        w_evt.brk = 1'b1;
                    end
                end
                GOT_E0F0_ST: begin
                    if (is_prefix(byte_in)) begin
                        w_err = 1'b1;
                    end else if (!is_shift(byte_in)) begin
                        w_emit    = 1'b1;
                        w_evt.ext = 1'b1;
                        w_evt.brk = 1'b1;
                    end
                end
                PAUSE_SKIP_ST: begin
                    if (w_tail_done) begin
                        w_emit = 1'b1;
                        w_evt  = '{ext: 1'b1, brk: 1'b0, code: BYTE_E1};
                    end
                end
                default: w_err = 1'b1;
            endcase
        end else begin
            w_err = w_timeout;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_skip_cnt <= '0;
        end else if (byte_new) begin
            r_skip_cnt <= (r_state == PAUSE_SKIP_ST) ? r_skip_cnt + 3'd1 : 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || byte_new || r_state == IDLE_ST || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    // Modifiers follow emitted events even when the FIFO drops them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift <= 1'b0;
            r_ctrl  <= 1'b0;
            r_alt   <= 1'b0;
        end else if (w_emit) begin
            if (!w_evt.ext && is_shift(w_evt.code)) r_shift <= !w_evt.brk;
            if (w_evt.code == CODE_CTRL)            r_ctrl  <= !w_evt.brk;
            if (w_evt.code == CODE_ALT)             r_alt   <= !w_evt.brk;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            r_err <= w_err;
            r_ovf <= w_drop;
        end
    end

    assign w_pop = ev_if.ev_ready & ~w_empty;

    kbd_evt_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_emit),
        .i_data  (w_evt),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (ev_count),
        .o_drop  (w_drop)
    );

    // Head fields are forced to zero while empty so nothing undefined leaves the block.
    assign ev_if.ev_valid = ~w_empty;
    assign ev_if.ev_code  = w_empty ? 8'h00 : w_head.code;
    assign ev_if.ev_ext   = ~w_empty & w_head.ext;
    assign ev_if.ev_brk   = ~w_empty & w_head.brk;

    assign mod_shift = r_shift;
    assign mod_ctrl  = r_ctrl;
    assign mod_alt   = r_alt;
    assign err       = r_err;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_kbd_scancode_ctrl.sv
// Directed bench for kbd_scancode_ctrl: expected events are queued as bytes are driven
// and compared in order whenever the consumer accepts the FIFO head.
module tb_kbd_scancode_ctrl;
    import kbd_pkg::*;

    localparam int DEPTH = 4;
    localparam int TMO   = 40;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] byte_in;
    logic       byte_new;
    logic [2:0] ev_count;
    logic       mod_shift;
    logic       mod_ctrl;
    logic       mod_alt;
    logic       err;
    logic       ovf;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    kbd_event_t exp_q[$];

    kbd_scancode_ctrl_if u_if ();

    kbd_scancode_ctrl #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .byte_in   (byte_in),
        .byte_new  (byte_new),
        .ev_if     (u_if.master),
        .ev_count  (ev_count),
        .mod_shift (mod_shift),
        .mod_ctrl  (mod_ctrl),
        .mod_alt   (mod_alt),
        .err       (err),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; drives one byte for exactly one cycle.
    task automatic send(input logic [7:0] b);
        byte_in  = b;
        byte_new = 1'b1;
        @(posedge clk);
        #1;
        byte_new = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_ev(input logic ext, input logic brk, input logic [7:0] code);
        exp_q.push_back('{ext: ext, brk: brk, code: code});
    endtask

    // Consumer side: outputs are stable at negedge and the pop happens at the next posedge.
    always @(negedge clk) begin
        if (!reset && u_if.ev_valid && u_if.ev_ready) begin
            check("event_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("event", {22'd0, u_if.ev_ext, u_if.ev_brk, u_if.ev_code},
                      {22'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        int n;
        reset         = 1'b1;
        byte_in       = 8'h00;
        byte_new      = 1'b0;
        u_if.ev_ready = 1'b0;
        idle(3);
        check("rst_valid", u_if.ev_valid, 1'b0);
        check("rst_count", ev_count, 3'd0);
        check("rst_mods", {mod_shift, mod_ctrl, mod_alt}, 3'b000);
        check("rst_err_ovf", {err, ovf}, 2'b00);
        reset         = 1'b0;
        u_if.ev_ready = 1'b1;
        idle(2);

        // Plain make and break, with one-cycle latency.
        expect_ev(0, 0, 8'h1C);
        send(8'h1C);
        check("make_latency", u_if.ev_valid, 1'b1);
        idle(3);
        expect_ev(0, 1, 8'h1C);
        send(8'hF0);
        check("f0_no_event", u_if.ev_valid, 1'b0);
        send(8'h1C);
        check("break_latency", u_if.ev_valid, 1'b1);
        idle(3);

        // Extended make/break and fake-shift filtering.
        expect_ev(1, 0, 8'h75);
        send(8'hE0); send(8'h75);
        expect_ev(1, 1, 8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        expect_ev(1, 0, 8'h7C);
        send(8'hE0); send(8'h12); send(8'hE0); send(8'h7C);
        check("fake_shift_mod", mod_shift, 1'b0);
        idle(3);

        // Pause sequence produces a single event, then IDLE decoding resumes.
        expect_ev(1, 0, 8'hE1);
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        check("pause_ctrl_untouched", mod_ctrl, 1'b0);
        expect_ev(0, 0, 8'h1C);
        send(8'h1C);
        idle(3);

        // Modifiers.
        expect_ev(0, 0, 8'h12);
        send(8'h12);
        check("shift_make", mod_shift, 1'b1);
        expect_ev(0, 1, 8'h12);
        send(8'hF0); send(8'h12);
        check("shift_break", mod_shift, 1'b0);
        expect_ev(1, 0, 8'h14);
        send(8'hE0); send(8'h14);
        check("ctrl_ext_make", mod_ctrl, 1'b1);
        expect_ev(0, 0, 8'h11);
        send(8'h11);
        check("alt_make", mod_alt, 1'b1);
        expect_ev(1, 1, 8'h11);
        send(8'hE0); send(8'hF0); send(8'h11);
        check("alt_ext_break", mod_alt, 1'b0);
        idle(3);

        // Protocol error: prefix after F0 pulses err and is then decoded from IDLE.
        send(8'hF0);
        send(8'hE0);
        check("proto_err_pulse", err, 1'b1);
        expect_ev(1, 0, 8'h75);
        send(8'h75);
        check("proto_err_cleared", err, 1'b0);
        idle(4);
        check("empty_pop_ignored", ev_count, 3'd0);

        // Overflow, then simultaneous pop and push while full.
        u_if.ev_ready = 1'b0;
        expect_ev(0, 0, 8'h15); send(8'h15);
        expect_ev(0, 0, 8'h16); send(8'h16);
        expect_ev(0, 0, 8'h1D); send(8'h1D);
        expect_ev(0, 0, 8'h24); send(8'h24);
        check("fill_no_ovf", ovf, 1'b0);
        check("fill_count", ev_count, 3'd4);
        send(8'h2D);
        check("ovf_pulse", ovf, 1'b1);
        check("ovf_count", ev_count, 3'd4);
        idle(1);
        check("ovf_single", ovf, 1'b0);
        u_if.ev_ready = 1'b1;
        expect_ev(0, 0, 8'h2E);
        send(8'h2E);
        u_if.ev_ready = 1'b0;
        check("full_pushpop_ovf", ovf, 1'b0);
        check("full_pushpop_count", ev_count, 3'd4);
        u_if.ev_ready = 1'b1;
        idle(8);

        // Timeout inside a partial sequence.
        send(8'hF0);
        n = 0;
        while (!err && n < TMO + 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("timeout_err", err, 1'b1);
        check("timeout_latency", 32'(n >= TMO - 1 && n <= TMO + 1), 32'd1);
        idle(1);
        check("timeout_err_pulse", err, 1'b0);
        expect_ev(0, 0, 8'h1C);
        send(8'h1C);
        idle(3);

        // Reset in the middle of a sequence with a queued event and a held modifier.
        u_if.ev_ready = 1'b0;
        send(8'h12);
        send(8'hE0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check("midrst_count", ev_count, 3'd0);
        check("midrst_valid", u_if.ev_valid, 1'b0);
        check("midrst_shift", mod_shift, 1'b0);
        u_if.ev_ready = 1'b1;
        expect_ev(0, 0, 8'h1C);
        send(8'h1C);
        idle(5);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
